// File: rtl/spi_mem_loader.sv
// SPI slave (mode 0) that writes bytes into, or streams bytes out of, a simple
// single-port memory. Frames are command byte, address byte, then data bytes.
module spi_mem_loader #(
  parameter int M = 162,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [$clog2(M)-1:0] mem_addr,
  output logic [N-1:0]         mem_wdata,
  output logic                 mem_we,
  input  logic [N-1:0]         mem_rdata,
  output logic                 busy,
  output logic                 addr_err
);

  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] ADDR_LAST = AW'(M - 1);
  localparam logic [AW:0]   M_EXT     = (AW + 1)'(M);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  state_t        state_q;
  logic [2:0]    sclk_q;
  logic [2:0]    cs_q;
  logic [1:0]    mosi_q;
  logic [2:0]    cnt_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  tx_q;
  logic [AW-1:0] mem_addr_q;
  logic [N-1:0]  mem_wdata_q;
  logic          mem_we_q;
  logic          busy_q;
  logic          addr_err_q;
  logic          rd_q;
  logic          wr_pend_q;
  logic          ld_pend_q;

  logic          sclk_rise;
  logic          sclk_fall;
  logic          cs_s;
  logic          cs_fall;
  logic          mosi_s;
  logic          byte_done;
  logic [N-1:0]  byte_val;
  logic          addr_oor;
  logic [AW-1:0] addr_inc;

  // Index 1 is the synchronized level, index 2 its previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  // cs_q resets low, so a frame already in progress at reset release never looks like a new start.
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign byte_val  = {shift_q[N-2:0], mosi_s};
  assign byte_done = sclk_rise & (cnt_q == 3'd7);
  assign addr_oor  = ({1'b0, mem_addr_q} >= M_EXT);
  assign addr_inc  = (mem_addr_q == ADDR_LAST) ? '0 : mem_addr_q + AW'(1);

  // Frame FSM with byte assembly, memory strobes and the read shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= '0;
      tx_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      rd_q        <= 1'b0;
      wr_pend_q   <= 1'b0;
      ld_pend_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (wr_pend_q) begin
        wr_pend_q  <= 1'b0;
        mem_addr_q <= addr_inc;
      end
      if ((state_q != ST_IDLE) && cs_s) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        cnt_q     <= 3'd0;
        tx_q      <= '0;
        ld_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            tx_q <= '0;
            if (cs_fall) begin
              state_q <= ST_CMD;
              busy_q  <= 1'b1;
              cnt_q   <= 3'd0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              case (byte_val)
                8'h01: begin
                  rd_q    <= 1'b0;
                  state_q <= ST_ADDR;
                end
                8'h02: begin
                  rd_q    <= 1'b1;
                  state_q <= ST_ADDR;
                end
                8'h03: begin
                  addr_err_q <= 1'b0;
                  state_q    <= ST_IGNORE;
                end
                default: state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              mem_addr_q <= AW'(byte_val);
              ld_pend_q  <= rd_q;
              state_q    <= rd_q ? ST_RDATA : ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (byte_done) begin
              mem_wdata_q <= byte_val;
              mem_we_q    <= ~addr_oor;
              wr_pend_q   <= 1'b1;
              if (addr_oor) begin
                addr_err_q <= 1'b1;
              end
            end
          end
          ST_RDATA: begin
            // The load waits for the falling edge so the address bump from the previous byte has settled.
            if (sclk_fall) begin
              if (ld_pend_q) begin
                tx_q      <= addr_oor ? '0 : mem_rdata;
                ld_pend_q <= 1'b0;
                if (addr_oor) begin
                  addr_err_q <= 1'b1;
                end
              end else begin
                tx_q <= {tx_q[N-2:0], 1'b0};
              end
            end
            if (byte_done) begin
              mem_addr_q <= addr_inc;
              ld_pend_q  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
        if (sclk_rise && (state_q != ST_IDLE)) begin
          cnt_q   <= cnt_q + 3'd1;
          shift_q <= byte_val;
        end
      end
    end
  end

  assign miso      = tx_q[N-1] & ~cs_s;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign addr_err  = addr_err_q;

endmodule

// File: doc/spi_mem_loader.md
SPI_MEM_LOADER -- requirements
Module: spi_mem_loader

Interface
REQ-001 Parameter M, default 162, number of memory locations.
REQ-002 Parameter N, default 8, memory word width; equals SPI byte width, fixed at 8.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  input  1  SPI data in, MSB first, sampled on sclk rising edge.
REQ-008 miso  output  1  SPI data out, MSB first, changes on sclk falling edge.
REQ-009 mem_addr  output  $clog2(M)  memory address, drives memory addr.
REQ-010 mem_wdata  output  N  write data, drives memory data_in.
REQ-011 mem_we  output  1  one-cycle write strobe, drives memory write_enable.
REQ-012 mem_rdata  input  N  memory data_out at mem_addr, combinational.
REQ-013 busy  output  1  high while a frame is active (synchronized cs_n low).
REQ-014 addr_err  output  1  sticky out-of-range access flag.

Function
REQ-015 sclk, cs_n, mosi each pass through a 2-flop synchronizer; sclk edges detected from synchronized history; clk frequency at least 4x sclk.
REQ-016 Byte assembly: 3-bit counter plus 8-bit shift register, MSB first; byte complete on 8th sampled rising edge.
REQ-017 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-018 IDLE -> CMD when synchronized cs_n falls; bit counter cleared.
REQ-019 CMD byte: 0x01 -> ADDR (write); 0x02 -> ADDR (read); 0x03 -> clear addr_err, then IGNORE; any other value -> IGNORE.
REQ-020 ADDR byte loads mem_addr, then WDATA or RDATA per command.
REQ-021 WDATA: each completed byte drives mem_wdata, and mem_we is high for exactly one clk cycle, the cycle after the byte completes; mem_addr increments the cycle after the strobe.
REQ-022 Address increment wraps M-1 -> 0; values >= M (from ADDR byte) increment up to 2^$clog2(M)-1 then wrap to 0.
REQ-023 Write to mem_addr >= M: no mem_we pulse; addr_err set; address still increments.
REQ-024 RDATA: tx register loads mem_rdata (0x00 if mem_addr >= M, addr_err set) on the first sclk falling edge after each completed byte, including the ADDR byte; the next 7 falling edges shift left; miso = tx MSB.
REQ-025 RDATA: mem_addr increments when each 8-bit read byte completes; mem_we stays 0.
REQ-026 IGNORE: all bytes discarded until cs_n rises.
REQ-027 cs_n rise in any state -> IDLE next cycle; partial byte discarded, no write; mem_addr holds its last value.
REQ-028 miso = 0 whenever not in RDATA or synchronized cs_n high.
REQ-029 busy = 1 in every state except IDLE.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, counters 0, mem_addr 0, mem_wdata 0, mem_we 0, miso 0, busy 0, addr_err 0.
REQ-031 rst_n low mid-frame aborts the frame; after release, logic waits in IDLE for a new cs_n falling edge, ignoring the remainder of the frame while cs_n stays low.

Verification
REQ-032 Write burst: cs_n low, bytes 0x01,0x05,0xAA,0xBB,0xCC, cs_n high -> three single-cycle mem_we pulses at addr 5,6,7 with data AA,BB,CC.
REQ-033 Wrap: write cmd, addr 161 (0xA1), data 0x11,0x22 -> writes addr 161 then 0; addr_err stays 0.
REQ-034 Read: memory model holds 0x3C@10, 0xC3@11; frame 0x02,0x0A, two dummy bytes -> miso returns 0x3C then 0xC3, MSB first; no mem_we.
REQ-035 Out-of-range: write cmd, addr 200, data 0x55 -> no mem_we, addr_err=1; subsequent frame 0x03 -> addr_err=0.
REQ-036 Abort: write cmd, addr 3, then 5 bits, cs_n high -> no mem_we, busy=0 within 3 clk; rst_n pulse mid-frame -> all outputs at reset values immediately.
